// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the emulated LTC2308 SPI responder.
// Config word layout is {S/D, O/S, S1, S0, UNI, SLP}.
package adc_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT
  } state_t;

  localparam int CFG_BITS = 6;
  localparam int NUM_CH   = 8;

  localparam int SD  = 5;
  localparam int OS  = 4;
  localparam int S1  = 3;
  localparam int S0  = 2;
  localparam int UNI = 1;
  localparam int SLP = 0;

  localparam logic [3:0] ADDR_CH0  = 4'd0;
  localparam logic [3:0] ADDR_CH7  = 4'd7;
  localparam logic [3:0] ADDR_RAMP = 4'd8;

  function automatic logic [2:0] sel_ch(
    input logic [CFG_BITS-1:0] cfg
  );
    return {cfg[S1], cfg[S0], cfg[OS]};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with registered
// rise/fall pulses; level is the synchronized value.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign level = chain[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// LTC2308-style ADC emulator: Avalon-written channel samples shifted out
// over SPI. Define ADC_RESP_RAMP_EN for the free-running ramp sample source.
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_BITS   = 12,
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic [3:0]          addr,
  input  logic [31:0]         writedata,
  input  logic                adc_convst,
  input  logic                adc_sck,
  input  logic                adc_sdi,
  output logic                adc_sdo,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                frame_done
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic convst_lvl, convst_rise, convst_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_convst (
    .clk   (sys_clk),
    .reset (reset),
    .din   (adc_convst),
    .level (convst_lvl),
    .rise  (convst_rise),
    .fall  (convst_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk   (sys_clk),
    .reset (reset),
    .din   (adc_sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk   (sys_clk),
    .reset (reset),
    .din   (adc_sdi),
    .level (sdi_lvl),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  logic unused;
  assign unused = ^{convst_lvl, convst_fall, sck_lvl,
                    sdi_rise, sdi_fall, writedata[31:DATA_BITS]};

  state_t                state;
  logic [DATA_BITS-1:0]  chan_reg [NUM_CH];
  logic [DATA_BITS-1:0]  shreg;
  logic [CW-1:0]         conv_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            cfg_cnt;
  logic [CFG_BITS-1:0]   cfg_sh;
  logic                  cfg_pend;
  logic                  cfg_full;
  logic                  wr_en;
  logic [DATA_BITS-1:0]  sample;

`ifdef ADC_RESP_RAMP_EN
  logic                  ramp_mode;
  logic [DATA_BITS-1:0]  ramp_cnt;
`endif

  assign wr_en    = chipselect & write;
  assign cfg_full = (cfg_cnt == 3'(CFG_BITS));

  // A fully captured config is the one in effect for the next sample,
  // whether or not its commit cycle has happened yet.
  always_comb begin
    sample = chan_reg[sel_ch(cfg_full ? cfg_sh : cfg_word)];
`ifdef ADC_RESP_RAMP_EN
    if (ramp_mode) sample = ramp_cnt;
`endif
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < NUM_CH; i++) chan_reg[i] <= '0;
      shreg      <= '0;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      cfg_cnt    <= '0;
      cfg_sh     <= '0;
      cfg_pend   <= 1'b0;
      cfg_word   <= '0;
      adc_sdo    <= 1'b0;
      frame_done <= 1'b0;
`ifdef ADC_RESP_RAMP_EN
      ramp_mode  <= 1'b0;
      ramp_cnt   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;

      if (wr_en && addr >= ADDR_CH0 && addr <= ADDR_CH7)
        chan_reg[addr[2:0]] <= writedata[DATA_BITS-1:0];
`ifdef ADC_RESP_RAMP_EN
      if (wr_en && addr == ADDR_RAMP)
        ramp_mode <= writedata[0];
`endif

      if (cfg_pend) begin
        cfg_word <= cfg_sh;
        cfg_pend <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          adc_sdo <= 1'b0;
          if (convst_rise) begin
            shreg    <= sample;
            conv_cnt <= CW'(CONV_CYCLES - 1);
            state    <= CONV;
          end
        end

        CONV: begin
          adc_sdo <= 1'b0;
          if (conv_cnt == '0) begin
            adc_sdo <= shreg[DATA_BITS-1];
            shreg   <= shreg << 1;
            bit_cnt <= BW'(1);
            cfg_cnt <= '0;
            state   <= SHIFT;
          end else begin
            conv_cnt <= conv_cnt - CW'(1);
          end
        end

        SHIFT: begin
          if (convst_rise) begin
            if (cfg_full) cfg_word <= cfg_sh;
            cfg_pend <= 1'b0;
            adc_sdo  <= 1'b0;
            shreg    <= sample;
            conv_cnt <= CW'(CONV_CYCLES - 1);
            state    <= CONV;
          end else begin
            if (sck_rise && cfg_cnt < 3'(CFG_BITS)) begin
              cfg_sh  <= {cfg_sh[CFG_BITS-2:0], sdi_lvl};
              cfg_cnt <= cfg_cnt + 3'd1;
              if (cfg_cnt == 3'(CFG_BITS - 1)) cfg_pend <= 1'b1;
            end
            if (sck_fall) begin
              if (bit_cnt < BW'(DATA_BITS)) begin
                adc_sdo <= shreg[DATA_BITS-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + BW'(1);
              end else begin
                adc_sdo    <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
`ifdef ADC_RESP_RAMP_EN
                ramp_cnt   <= ramp_cnt + DATA_BITS'(1);
`endif
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
